// File: rtl/decim_filt.sv
// Decimation filter: averages a packed frame of RATIO unsigned samples into one sample
// with a serial accumulator. Define DECIM_ROUND_EN for round-half-up instead of truncation.
module decim_filt #(
    parameter int SAMPLE_W = 4,
    parameter int RATIO    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SAMPLE_W*RATIO-1:0]    in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [SAMPLE_W-1:0]          out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy
);
    localparam int LOG2  = $clog2(RATIO);
    localparam int ACC_W = SAMPLE_W + LOG2;
    localparam int IDX_W = LOG2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t                      state_reg, state_next;
    logic [ACC_W-1:0]            acc_reg, acc_next;
    logic [IDX_W-1:0]            idx_reg, idx_next;
    logic [SAMPLE_W*RATIO-1:0]   frame_reg, frame_next;
    logic [SAMPLE_W-1:0]         out_data_reg, out_data_next;

    logic [SAMPLE_W-1:0]         samples [RATIO];
    logic [ACC_W-1:0]            sum_full;
    logic [SAMPLE_W-1:0]         avg;

    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_unpack
            assign samples[gi] = frame_reg[gi*SAMPLE_W +: SAMPLE_W];
        end
    endgenerate

    assign sum_full = acc_reg + ACC_W'(samples[idx_reg]);

`ifdef DECIM_ROUND_EN
    // Offset cannot overflow ACC_W: max sum is RATIO*(2^SAMPLE_W-1), plus RATIO/2.
    logic [ACC_W-1:0] rounded;
    logic [LOG2-1:0]  unused_round_bits;
    assign rounded           = sum_full + ACC_W'(RATIO / 2);
    assign avg               = rounded[ACC_W-1:LOG2];
    assign unused_round_bits = rounded[LOG2-1:0];
`else
    assign avg = sum_full[ACC_W-1:LOG2];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            acc_reg      <= '0;
            idx_reg      <= '0;
            frame_reg    <= '0;
            out_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            acc_reg      <= acc_next;
            idx_reg      <= idx_next;
            frame_reg    <= frame_next;
            out_data_reg <= out_data_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        acc_next      = acc_reg;
        idx_next      = idx_reg;
        frame_next    = frame_reg;
        out_data_next = out_data_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    frame_next = in_data;
                    acc_next   = '0;
                    idx_next   = '0;
                    state_next = ACC;
                end
            end
            ACC: begin
                acc_next = sum_full;
                idx_next = idx_reg + IDX_W'(1);
                if (idx_reg == LAST_IDX) begin
                    out_data_next = avg;
                    state_next    = OUT;
                end
            end
            OUT: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // in_ready is gated by rst so it drops the moment reset is asserted.
    assign in_ready  = (state_reg == IDLE) && !rst;
    assign busy      = (state_reg != IDLE);
    assign out_valid = (state_reg == OUT);
    assign out_data  = out_data_reg;
endmodule

// File: tb/tb_decim_filt.sv
// Scoreboard bench for decim_filt: stimulus pushes expected averages, a negedge
// monitor pops and compares on every out_valid/out_ready handshake.
module tb_decim_filt;
    localparam int SAMPLE_W = 4;
    localparam int RATIO    = 4;

`ifdef DECIM_ROUND_EN
    localparam int EXP_4321 = 3;
    localparam int EXP_0011 = 1;
`else
    localparam int EXP_4321 = 2;
    localparam int EXP_0011 = 0;
`endif

    logic                      clk = 1'b0;
    logic                      rst;
    logic [SAMPLE_W*RATIO-1:0] in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic [SAMPLE_W-1:0]       out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic                      busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int exp_q[$];

    decim_filt #(.SAMPLE_W(SAMPLE_W), .RATIO(RATIO)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Monitor: the handshake completes on the following rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", int'(out_data), -1);
            end else begin
                int e;
                e = exp_q.pop_front();
                $display("out_data=%0d expected=%0d cycle=%0d", out_data, e, cyc);
                chk("out_data", int'(out_data), e);
            end
        end
    end

    task automatic run_frame(input logic [15:0] data, input int exp, input string tag);
        int n;
        chk({tag, "_ready_before"}, int'(in_ready), 1);
        in_data  = data;
        in_valid = 1'b1;
        exp_q.push_back(exp);
        tick();
        in_valid = 1'b0;
        chk({tag, "_ready_after_accept"}, int'(in_ready), 0);
        chk({tag, "_busy_after_accept"}, int'(busy), 1);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, RATIO);
        n = 0;
        while (out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid_cleared"}, int'(out_valid), 0);
        chk({tag, "_ready_idle"}, int'(in_ready), 1);
    endtask

    initial begin
        int n;
        int acc_cycle[2];
        int accepts;
        logic will_accept;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #12;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_data", int'(out_data), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);

        // 1: basic average and latency
        run_frame(16'h4321, EXP_4321, "t1");

        // 2: extremes
        run_frame(16'hFFFF, 15, "t2_max");
        run_frame(16'h0000, 0, "t2_zero");

        // 3: backpressure with a competing frame held on the input
        out_ready = 1'b0;
        in_data   = 16'h8888;
        in_valid  = 1'b1;
        exp_q.push_back(8);
        tick();
        in_data = 16'h1111;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("t3_latency", n, RATIO);
        for (int i = 0; i < 6; i++) begin
            chk("t3_hold_valid", int'(out_valid), 1);
            chk("t3_hold_data", int'(out_data), 8);
            chk("t3_hold_ready", int'(in_ready), 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("t3_valid_fall", int'(out_valid), 0);
        chk("t3_back_idle", int'(in_ready), 1);
        exp_q.push_back(1);
        tick();
        in_valid = 1'b0;
        chk("t3_second_accepted", int'(busy), 1);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("t3_second_latency", n, RATIO);
        tick();

        // 4: back-to-back frames, accept spacing
        in_data  = 16'h2222;
        in_valid = 1'b1;
        exp_q.push_back(2);
        accepts = 0;
        n = 0;
        while (accepts < 2 && n < 40) begin
            will_accept = in_ready && in_valid;
            tick();
            n++;
            if (will_accept) begin
                acc_cycle[accepts] = cyc;
                accepts++;
                if (accepts == 1) begin
                    in_data = 16'h6666;
                    exp_q.push_back(6);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("t4_accepts", accepts, 2);
        chk("t4_spacing", acc_cycle[1] - acc_cycle[0], RATIO + 2);
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        tick();

        // 5: reset mid-accumulation
        in_data  = 16'hFFFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_out_valid", int'(out_valid), 0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_in_ready", int'(in_ready), 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("t5_release_in_ready", int'(in_ready), 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t5_no_stale", int'(out_valid), 0);
        end
        run_frame(16'h4321, EXP_4321, "t5_fresh");

        // 6: rounding boundary
        run_frame(16'h0011, EXP_0011, "t6_sum2");
        run_frame(16'h0001, 0, "t6_sum1");

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/decim_filt.md
Name: decim_filt

Overview:
- Decimation filter: the receive-side counterpart of the interpolation filter.
- Accepts one frame of RATIO packed SAMPLE_W-bit unsigned samples and emits one SAMPLE_W-bit sample, the boxcar average of the frame.
- Frame packing matches the interpolation filter output: sample 0 in bits [SAMPLE_W-1:0], the earliest sample.
- Sequential serial accumulator with valid/ready handshakes on both sides.

Parameters:
SAMPLE_W, 4, width of one sample in bits.
RATIO, 4, samples per frame (decimation ratio). Must be a power of 2, at least 2.

Ports:
clk  input  1  clock, all state on rising edge.
rst  input  1  asynchronous, active-high reset.
in_data  input  SAMPLE_W*RATIO  packed frame; sample k in bits [k*SAMPLE_W +: SAMPLE_W].
in_valid  input  1  frame present on in_data.
in_ready  output  1  block can accept a frame.
out_data  output  SAMPLE_W  decimated sample.
out_valid  output  1  out_data holds a result.
out_ready  input  1  downstream accepts out_data.
busy  output  1  high in ACC or OUT.

Behaviour:
- Reset (async, takes effect immediately) clears all state:
  - in_ready=0 while rst is high, 1 after release.
  - out_valid=0, out_data=0, busy=0.
  - Internal registers cleared: state=IDLE, accumulator=0, index=0, frame register=0.
- Accumulator width is SAMPLE_W+log2(RATIO) bits, so the sum never overflows.
- State IDLE:
  - in_ready=1, busy=0.
  - On an edge with in_valid=1: register in_data, clear accumulator, set index=0, go to ACC.
- State ACC:
  - in_ready=0, busy=1.
  - Each edge adds sample[index] to the accumulator and increments index.
  - On the edge that adds sample[RATIO-1]: register out_data = f(accumulator + sample[RATIO-1]), set out_valid=1, go to OUT.
- State OUT:
  - in_ready=0, busy=1, out_valid=1.
  - out_data holds stable until an edge with out_ready=1.
  - On that edge: out_valid=0, go to IDLE.
  - No same-cycle re-accept: in_ready only rises in IDLE.
- Latency: the frame is accepted at edge 0 and out_valid rises at edge RATIO (4 cycles by default).
- Throughput: at most one frame per RATIO+2 cycles with out_ready tied high.
- Truncating average: f(sum) = sum >> log2(RATIO).
- in_valid is ignored outside IDLE; in_data is only sampled at the accept edge.
- out_ready is ignored outside OUT.
- Reset during ACC or OUT:
  - The frame in progress is discarded; no partial output appears.
  - out_valid falls immediately.
- All-zero frame produces 0; all-max frame produces 2^SAMPLE_W-1.
- Neither result wraps, in either mode.

Optional Feature:
- Macro DECIM_ROUND_EN.
- Defined: round-half-up average, f(sum) = (sum + RATIO/2) >> log2(RATIO). The sum-plus-offset is computed at SAMPLE_W+log2(RATIO) bits. The result is guaranteed to fit in SAMPLE_W bits because the max sum is RATIO*(2^SAMPLE_W-1).
- Undefined: truncating average as described in Behaviour.
- Latency, handshakes and reset behaviour are identical in both builds.

Test Plan:
1. Reset, then in_data=16'h4321 with in_valid for 1 cycle. Samples 1,2,3,4, sum=10. Expected: out_valid rises at edge 4 after accept; out_data=2 (truncating) or 3 (DECIM_ROUND_EN). in_ready=0 from the accept edge until return to IDLE.
2. in_data=16'hFFFF -> out_data=15 in both builds. in_data=16'h0000 -> out_data=0.
3. Frame 16'h8888 (sum=32), out_ready held low 6 cycles, with in_valid=1 and in_data=16'h1111 driven throughout. Expected: out_data=8 held stable, in_ready=0, the 16'h1111 frame is not accepted. Then raise out_ready: out_valid falls, back to IDLE, and 16'h1111 is accepted next edge, giving 1.
4. Back-to-back frames 16'h2222 then 16'h6666 with out_ready=1 and in_valid=1 continuously. Expected outputs 2 then 6. Accept edges spaced exactly RATIO+2=6 cycles apart.
5. Assert rst mid-ACC after 2 accumulate edges of 16'hFFFF. Expected: out_valid=0, busy=0, in_ready=0 immediately (async). After release, in_ready=1 and no stale output appears. A fresh 16'h4321 frame then yields 2 (or 3 with DECIM_ROUND_EN).
6. Rounding boundary, 16'h0011 (sum=2). Expected: 0 truncating, 1 with DECIM_ROUND_EN. 16'h0001 (sum=1) gives 0 in both builds.
